// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg: shared types and helpers for the RAM image loader.
//   loader_state_t  - loader FSM state encoding
//   LAT_W           - width of the read-back latency counter (RD_LATENCY 1..4)
//   bytes_per_word  - number of byte lanes in a RAM word
//   idx_width       - width of a byte-lane index (never narrower than 1 bit)
package ram_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_RDBACK  = 3'd3,
        ST_DONE    = 3'd4
    } loader_state_t;

    localparam int LAT_W = 2;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

    // A one-lane word still needs a 1-bit index so the packer's vectors stay legal.
    function automatic int idx_width(input int data_w);
        int bpw;
        bpw = data_w / 8;
        return (bpw > 1) ? $clog2(bpw) : 1;
    endfunction

endpackage

// File: rtl/ram_loader_if.sv
// ram_loader_if: byte-stream input plus RAM cs/we/oe port of the loader.
//   byte_in/byte_valid/byte_last  stream source -> loader
//   byte_ready                    loader -> stream source
//   address/data_input/cs/we/oe   loader -> RAM
//   data_output                   RAM -> loader
//
// Stream handshake: a byte transfers on the rising clk edge where
// byte_valid && byte_ready are both high; byte_in and byte_last are only
// meaningful while byte_valid is high, and the source may raise byte_valid
// without waiting for byte_ready.
interface ram_loader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_last;
    logic              byte_ready;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_input;
    logic [DATA_W-1:0] data_output;
    logic              cs;
    logic              we;
    logic              oe;

    // The loader side.
    modport master (
        input  byte_in, byte_valid, byte_last, data_output,
        output byte_ready, address, data_input, cs, we, oe
    );

    // The stream source and RAM side.
    modport slave (
        output byte_in, byte_valid, byte_last, data_output,
        input  byte_ready, address, data_input, cs, we, oe
    );
endinterface

// File: rtl/ram_loader_byte_packer.sv
// ram_loader_byte_packer: assembles stream bytes little-endian into one RAM word.
//   clk, rst     clock, synchronous active-high reset
//   clear_i      drop the staged word and restart at lane 0
//   accept_i     a byte is being accepted this cycle
//   last_i       the accepted byte ends the image
//   byte_i       the accepted byte
//   word_o       staged word with the incoming byte merged into its lane
//   complete_o   the accepted byte finishes a word (full or last)
//   pending_o    a partial word is held
module ram_loader_byte_packer
    import ram_loader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              accept_i,
    input  logic              last_i,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] word_o,
    output logic              complete_o,
    output logic              pending_o
);

    localparam int BPW   = bytes_per_word(DATA_W);
    localparam int IDX_W = idx_width(DATA_W);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BPW - 1);

    logic [DATA_W-1:0] lanes_q, lanes_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              full_q, full_d;
    logic              take;
    logic [DATA_W-1:0] lane_word;

    // A completed word blocks further bytes until it has been consumed.
    assign take = accept_i && !full_q;

    // Lanes above the current index are still zero, which zero-pads a short last word.
    assign lane_word  = lanes_q | (DATA_W'(byte_i) << {idx_q, 3'b000});
    assign word_o     = take ? lane_word : lanes_q;
    assign complete_o = take && (last_i || (idx_q == IDX_LAST));
    assign pending_o  = (idx_q != '0);

    always_comb begin
        lanes_d = lanes_q;
        idx_d   = idx_q;
        full_d  = full_q;
        if (clear_i) begin
            lanes_d = '0;
            idx_d   = '0;
            full_d  = 1'b0;
        end else if (take) begin
            lanes_d = lane_word;
            if (complete_o) begin
                idx_d  = '0;
                full_d = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lanes_q <= '0;
            idx_q   <= '0;
            full_q  <= 1'b0;
        end else begin
            lanes_q <= lanes_d;
            idx_q   <= idx_d;
            full_q  <= full_d;
        end
    end

endmodule

// File: rtl/ram_loader.sv
// ram_loader: boot-image loader. Packs a byte stream little-endian into RAM
// words, writes them sequentially from BASE_ADDR, optionally reads each word
// back and compares it, then raises done.
//   clk, rst      clock, synchronous active-high reset
//   start         pulse; begins a load from IDLE or DONE
//   bus           ram_loader_if.master: byte stream in, RAM cs/we/oe port out
//   word_count    words written so far
//   done          load finished; held until start or rst
//   error         read-back mismatch or DEPTH overflow; sticky with done
//   dbg_state_o   current FSM state
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                DEPTH      = 1024,
    parameter int                VERIFY     = 1,
    parameter int                RD_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    ram_loader_if.master                 bus,
    output logic [$clog2(DEPTH+1)-1:0]   word_count,
    output logic                         done,
    output logic                         error,
    output loader_state_t                dbg_state_o
);

    localparam int BPW   = bytes_per_word(DATA_W);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BPW);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              cs_q, cs_d;
    logic              we_q, we_d;
    logic              oe_q, oe_d;
    logic              rdy_q, rdy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              last_q, last_d;

    logic              byte_take;
    logic              overflow;
    logic              start_ok;
    logic              pkr_accept;
    logic              pkr_clear;
    logic              pkr_complete;
    logic              pkr_pending;
    logic [DATA_W-1:0] pkr_word;

    // rdy_q is only high in COLLECT, so this is the stream transfer condition.
    assign byte_take = bus.byte_valid && rdy_q;

    // A new word's first byte arriving once DEPTH words are stored has nowhere to go.
    assign overflow   = byte_take && (wcnt_q == DEPTH_CNT) && !pkr_pending;
    assign start_ok   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign pkr_accept = byte_take && !overflow;
    // The staged word is consumed by the WRITE cycle; a fresh load starts empty.
    assign pkr_clear  = start_ok || (state_q == ST_WRITE);

    ram_loader_byte_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (pkr_clear),
        .accept_i   (pkr_accept),
        .last_i     (bus.byte_last),
        .byte_i     (bus.byte_in),
        .word_o     (pkr_word),
        .complete_o (pkr_complete),
        .pending_o  (pkr_pending)
    );

    // Next-state logic. The RAM strobes, byte_ready and done are decoded from
    // the next state and registered, so every output is a flop.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wcnt_d  = wcnt_q;
        lat_d   = lat_q;
        err_d   = err_q;
        last_d  = last_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_d = ST_COLLECT;
                    addr_d  = BASE_ADDR;
                    wdata_d = '0;
                    wcnt_d  = '0;
                    lat_d   = '0;
                    err_d   = 1'b0;
                    last_d  = 1'b0;
                end
            end

            ST_COLLECT: begin
                if (overflow) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (pkr_complete) begin
                    wdata_d = pkr_word;
                    last_d  = bus.byte_last;
                    state_d = ST_WRITE;
                end
            end

            ST_WRITE: begin
                wcnt_d = wcnt_q + CNT_W'(1);
                if (VERIFY != 0) begin
                    lat_d   = '0;
                    state_d = ST_RDBACK;
                end else begin
                    addr_d  = addr_q + ADDR_STEP;
                    state_d = last_q ? ST_DONE : ST_COLLECT;
                end
            end

            ST_RDBACK: begin
                // The RAM's data is only valid on the last cycle of the hold.
                if (lat_q == LAT_LAST) begin
                    addr_d = addr_q + ADDR_STEP;
                    if (bus.data_output != wdata_q) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = last_q ? ST_DONE : ST_COLLECT;
                    end
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rdy_d  = (state_d == ST_COLLECT);
        cs_d   = (state_d == ST_WRITE) || (state_d == ST_RDBACK);
        we_d   = (state_d == ST_WRITE);
        oe_d   = (state_d == ST_RDBACK);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            wcnt_q  <= '0;
            lat_q   <= '0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            oe_q    <= 1'b0;
            rdy_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wcnt_q  <= wcnt_d;
            lat_q   <= lat_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            oe_q    <= oe_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            last_q  <= last_d;
        end
    end

    assign bus.byte_ready = rdy_q;
    assign bus.address    = addr_q;
    assign bus.data_input = wdata_q;
    assign bus.cs         = cs_q;
    assign bus.we         = we_q;
    assign bus.oe         = oe_q;
    assign word_count     = wcnt_q;
    assign done           = done_q;
    assign error          = err_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: three loader configurations share one stream driver and one
// RAM model; sel picks which instance is live at a time.
//   sel 0: defaults (32-bit, VERIFY=1, RD_LATENCY=1)
//   sel 1: DEPTH=2, VERIFY=0
//   sel 2: DATA_W=16, BASE_ADDR=0x100, RD_LATENCY=3
module tb_ram_loader;
    import ram_loader_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_r;
    logic [7:0] byte_in_r;
    logic       byte_valid_r;
    logic       byte_last_r;
    int         sel;
    logic       corrupt_en;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q[$];   // {address, data} of each expected RAM write

    ram_loader_if #(.DATA_W(32), .ADDR_W(32)) a_if ();
    ram_loader_if #(.DATA_W(32), .ADDR_W(32)) b_if ();
    ram_loader_if #(.DATA_W(16), .ADDR_W(32)) c_if ();

    logic [10:0]   a_wc, c_wc;
    logic [1:0]    b_wc;
    logic          a_done, b_done, c_done, a_err, b_err, c_err;
    loader_state_t a_st, b_st, c_st;

    ram_loader #(.DATA_W(32), .ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH(1024), .VERIFY(1), .RD_LATENCY(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_r && (sel == 0)), .bus(a_if),
        .word_count(a_wc), .done(a_done), .error(a_err), .dbg_state_o(a_st));

    ram_loader #(.DATA_W(32), .ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH(2), .VERIFY(0), .RD_LATENCY(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_r && (sel == 1)), .bus(b_if),
        .word_count(b_wc), .done(b_done), .error(b_err), .dbg_state_o(b_st));

    ram_loader #(.DATA_W(16), .ADDR_W(32), .BASE_ADDR(32'h100), .DEPTH(1024), .VERIFY(1), .RD_LATENCY(3)) dut_c (
        .clk(clk), .rst(rst), .start(start_r && (sel == 2)), .bus(c_if),
        .word_count(c_wc), .done(c_done), .error(c_err), .dbg_state_o(c_st));

    // ---------------- selection muxes ----------------
    logic        cs_m, we_m, oe_m, rdy_m, done_m, err_m;
    logic [31:0] addr_m, wdata_m, rd_m;
    int          wc_m, lat_m;

    always_comb begin
        case (sel)
            0: begin
                cs_m = a_if.cs; we_m = a_if.we; oe_m = a_if.oe; rdy_m = a_if.byte_ready;
                addr_m = a_if.address; wdata_m = a_if.data_input;
                done_m = a_done; err_m = a_err; wc_m = int'(a_wc); lat_m = 1;
            end
            1: begin
                cs_m = b_if.cs; we_m = b_if.we; oe_m = b_if.oe; rdy_m = b_if.byte_ready;
                addr_m = b_if.address; wdata_m = b_if.data_input;
                done_m = b_done; err_m = b_err; wc_m = int'(b_wc); lat_m = 1;
            end
            default: begin
                cs_m = c_if.cs; we_m = c_if.we; oe_m = c_if.oe; rdy_m = c_if.byte_ready;
                addr_m = c_if.address; wdata_m = {16'h0, c_if.data_input};
                done_m = c_done; err_m = c_err; wc_m = int'(c_wc); lat_m = 3;
            end
        endcase
    end

    assign a_if.byte_in = byte_in_r;  assign a_if.byte_last = byte_last_r;
    assign b_if.byte_in = byte_in_r;  assign b_if.byte_last = byte_last_r;
    assign c_if.byte_in = byte_in_r;  assign c_if.byte_last = byte_last_r;
    assign a_if.byte_valid = byte_valid_r && (sel == 0);
    assign b_if.byte_valid = byte_valid_r && (sel == 1);
    assign c_if.byte_valid = byte_valid_r && (sel == 2);
    assign a_if.data_output = rd_m;
    assign b_if.data_output = rd_m;
    assign c_if.data_output = rd_m[15:0];

    // ---------------- RAM model ----------------
    // Read data is valid only on the lat_m-th consecutive oe cycle; before that
    // it shows a garbage pattern so an early compare is caught.
    logic [31:0] mem [0:255];
    int          ram_run = 0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    end

    always @(posedge clk) begin
        if (cs_m && we_m) mem[addr_m[8:1]] <= wdata_m;
        ram_run <= oe_m ? ram_run + 1 : 0;
    end

    always_comb begin
        rd_m = 32'hA5A5_5A5A;
        if (oe_m && (ram_run == lat_m - 1)) begin
            rd_m = mem[addr_m[8:1]];
            if (corrupt_en && (sel == 0) && (addr_m == 32'h4)) rd_m = rd_m ^ 32'h1;
        end
    end

    // ---------------- scoreboard ----------------
    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endfunction

    // Monitor: pops one expected write per write strobe and measures each oe burst.
    initial begin
        int          oe_len;
        logic [63:0] got;
        oe_len = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                oe_len = 0;
            end else begin
                if (cs_m && we_m) begin
                    got = {addr_m, wdata_m};
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write got=%h expected=none", got);
                    end else begin
                        check("write", got, exp_q.pop_front());
                    end
                end
                if (oe_m) begin
                    oe_len++;
                end else if (oe_len != 0) begin
                    check("rdback_len", 64'(oe_len), 64'(lat_m));
                    oe_len = 0;
                end
            end
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic pulse_start();
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
    endtask

    // Sends n bytes b0, b0+step, ...; stops early if the loader reaches DONE.
    task automatic send_seq(input logic [7:0] b0, input logic [7:0] step, input int n,
                            input bit with_last, output int acc);
        int         w;
        logic [7:0] b;
        acc = 0;
        b = b0;
        for (int i = 0; i < n; i++) begin
            byte_in_r    = b;
            byte_last_r  = with_last && (i == n - 1);
            byte_valid_r = 1'b1;
            w = 0;
            while (!rdy_m && !done_m && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (!rdy_m) begin
                if (!done_m) begin
                    checks++;
                    failures++;
                    $display("FAIL drv_timeout got=byte%0d expected=accepted", i);
                end
                break;
            end
            @(negedge clk);
            acc++;
            b = b + step;
        end
        byte_valid_r = 1'b0;
        byte_last_r  = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done_m && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done_m) begin
            checks++;
            failures++;
            $display("FAIL done_timeout got=0 expected=1");
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int acc, n;
        rst = 1'b1; start_r = 1'b0; byte_in_r = 8'h0; byte_valid_r = 1'b0;
        byte_last_r = 1'b0; sel = 0; corrupt_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_strobes", {a_if.cs, a_if.we, a_if.oe, a_if.byte_ready}, 0);
        check("rst_flags", {a_done, a_err}, 0);
        check("rst_addr", a_if.address, 0);
        check("rst_wdata", a_if.data_input, 0);
        check("rst_wcnt", a_wc, 0);
        check("rst_state", a_st, ST_IDLE);
        check("rst_addr_c", c_if.address, 32'h100);

        // 12 bytes 01..0C
        exp_q.push_back({32'h0, 32'h04030201});
        exp_q.push_back({32'h4, 32'h08070605});
        exp_q.push_back({32'h8, 32'h0C0B0A09});
        pulse_start();
        send_seq(8'h01, 8'h01, 12, 1'b1, acc);
        wait_done(n);
        check("t1_done_lat", 64'(n), 2);
        check("t1_flags", {done_m, err_m}, 2'b10);
        check("t1_wcnt", 64'(wc_m), 3);
        check("t1_q_empty", 64'(exp_q.size()), 0);

        // 6 bytes AA..AF: zero-padded second word
        exp_q.push_back({32'h0, 32'hADACABAA});
        exp_q.push_back({32'h4, 32'h0000AFAE});
        pulse_start();
        send_seq(8'hAA, 8'h01, 6, 1'b1, acc);
        wait_done(n);
        check("t2_done_lat", 64'(n), 2);
        check("t2_flags", {done_m, err_m}, 2'b10);
        check("t2_wcnt", 64'(wc_m), 2);
        check("t2_q_empty", 64'(exp_q.size()), 0);

        // Read-back corruption at address 4
        corrupt_en = 1'b1;
        exp_q.push_back({32'h0, 32'h04030201});
        exp_q.push_back({32'h4, 32'h08070605});
        pulse_start();
        send_seq(8'h01, 8'h01, 12, 1'b1, acc);
        wait_done(n);
        repeat (3) @(negedge clk);
        check("t3_flags", {done_m, err_m}, 2'b11);
        check("t3_accepted", 64'(acc), 8);
        check("t3_wcnt", 64'(wc_m), 2);
        check("t3_q_empty", 64'(exp_q.size()), 0);
        corrupt_en = 1'b0;

        // rst after 2 bytes of the second word, then restart
        exp_q.push_back({32'h0, 32'h04030201});
        pulse_start();
        send_seq(8'h01, 8'h01, 6, 1'b0, acc);
        check("t4_accepted", 64'(acc), 6);
        rst = 1'b1;
        @(negedge clk);
        check("t4_strobes", {a_if.cs, a_if.we, a_if.oe}, 0);
        check("t4_addr", a_if.address, 0);
        check("t4_state", a_st, ST_IDLE);
        rst = 1'b0;
        exp_q.push_back({32'h0, 32'h88776655});
        @(negedge clk);
        pulse_start();
        send_seq(8'h55, 8'h11, 4, 1'b1, acc);
        wait_done(n);
        check("t4_flags", {done_m, err_m}, 2'b10);
        check("t4_wcnt", 64'(wc_m), 1);
        check("t4_q_empty", 64'(exp_q.size()), 0);

        // DEPTH=2 overflow on byte 9
        sel = 1;
        exp_q.push_back({32'h0, 32'h04030201});
        exp_q.push_back({32'h4, 32'h08070605});
        pulse_start();
        send_seq(8'h01, 8'h01, 12, 1'b1, acc);
        wait_done(n);
        check("t5_accepted", 64'(acc), 9);
        check("t5_done_lat", 64'(n), 0);
        check("t5_flags", {done_m, err_m}, 2'b11);
        check("t5_addr", addr_m, 32'h8);
        check("t5_wcnt", 64'(wc_m), 2);
        check("t5_q_empty", 64'(exp_q.size()), 0);

        // 16-bit words at 0x100, RD_LATENCY=3
        sel = 2;
        exp_q.push_back({32'h100, 32'h00002211});
        exp_q.push_back({32'h102, 32'h00000033});
        pulse_start();
        send_seq(8'h11, 8'h11, 3, 1'b1, acc);
        wait_done(n);
        check("t6_done_lat", 64'(n), 4);
        check("t6_flags", {done_m, err_m}, 2'b10);
        check("t6_wcnt", 64'(wc_m), 2);
        check("t6_q_empty", 64'(exp_q.size()), 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_loader.md
# ram_loader

Synthesizable, parametrised loader that takes an object image as a byte stream, packs bytes little-endian into RAM words, and writes them sequentially into the system RAM over its cs/we/oe port. It can read back and compare each written word. It is the boot path for ARM test programs: it fills instruction/data memory before the core is released from reset, then raises `done`.

## Interface
Parameters:
- DATA_W, 32, RAM word width; multiple of 8, 8..64
- ADDR_W, 32, RAM byte-address width
- BASE_ADDR, 0, byte address of the first word written
- DEPTH, 1024, maximum number of words accepted
- VERIFY, 1, 1 = read back and compare every word after it is written
- RD_LATENCY, 1, cycles from oe/address valid to data_output valid; range 1..4

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  pulse; begins a load from IDLE or DONE
- byte_in  in  8  stream byte
- byte_valid  in  1  byte_in valid
- byte_last  in  1  marks the final byte of the image
- byte_ready  out  1  loader accepts byte this cycle
- address  out  ADDR_W  RAM byte address
- data_input  out  DATA_W  RAM write data
- data_output  in  DATA_W  RAM read data
- cs, we, oe  out  1 each  RAM chip select, write enable, output enable
- word_count  out  $clog2(DEPTH+1)  words written so far
- done  out  1  load finished; held until start or rst
- error  out  1  verify mismatch or DEPTH overflow; sticky with done

## Operation
- States: IDLE, COLLECT, WRITE, RDBACK, DONE.
- IDLE: all outputs at reset values. `start` moves to COLLECT, clears done, error, and word_count, and loads address with BASE_ADDR.
- COLLECT: byte_ready=1. The first byte of a word goes to bits [7:0], the next to [15:8], and so on. Leave COLLECT when the word is full or an accepted byte has byte_last=1. A partial last word is zero-padded in the upper bytes.
- WRITE: one cycle with cs=1, we=1, oe=0, data_input holding the packed word, address current. word_count increments.
  - VERIFY=0: go to COLLECT, or to DONE if last.
  - VERIFY=1: go to RDBACK.
- RDBACK: cs=1, oe=1, we=0, same address, held RD_LATENCY cycles. On the final cycle, compare data_output to the written word.
  - Mismatch: error=1, go to DONE.
  - Match: go to COLLECT, or to DONE if last.
- address advances by DATA_W/8 when leaving WRITE (VERIFY=0) or RDBACK (VERIFY=1). It wraps modulo 2^ADDR_W.
- DEPTH overflow: a byte accepted when word_count==DEPTH and no partial word is pending sets error=1 and moves to DONE. Nothing is written.
- DONE: done=1 and cs=we=oe=0. `start` restarts the load as from IDLE.
- `start` while in COLLECT, WRITE, or RDBACK is ignored.
- byte_last on an empty stream is impossible, because every accepted byte belongs to a word. A `start` followed by no bytes stays in COLLECT indefinitely.

## Timing
- Reset values: cs=0, we=0, oe=0, byte_ready=0, done=0, error=0, address=BASE_ADDR, data_input=0, word_count=0; state IDLE.
- rst mid-load: state returns to IDLE on the next edge. No write strobe follows. A partial word is discarded.
- All outputs are registered.
- A byte is accepted on a clk edge with byte_valid && byte_ready.
- Write strobe: the cycle after the edge that accepts the completing byte.
- Per-word cost:
  - VERIFY=0: DATA_W/8 + 1 cycles.
  - VERIFY=1: DATA_W/8 + 1 + RD_LATENCY cycles.
- done rises the cycle after the final WRITE (VERIFY=0) or the final RDBACK cycle (VERIFY=1).

## Structure
- ram_loader_pkg:
  - state enum `loader_state_t`
  - function computing bytes-per-word from DATA_W
- Sub-module byte_packer: shift/lane register with byte index counter, full flag, and zero-padding. It is cleared by rst, start, and word consumption.
- The top level holds the FSM, address/word counters, the RDBACK latency counter, and the compare.

## Test plan
- Defaults, 12 bytes 01..0C, last on 0C:
  - writes 0x04030201@0, 0x08070605@4, 0x0C0B0A09@8
  - word_count=3, done=1, error=0
- 6 bytes AA..AF, last on AF:
  - second word 0x0000AFAE@4 (zero-padded)
- VERIFY=1 with the RAM model corrupting bit 0 at address 4:
  - error=1 and done=1 after the second RDBACK
  - no write to address 8
- DEPTH=2, 12 bytes:
  - two writes, then error=1 on byte 9
  - address=8, word_count=2
- rst asserted after 2 bytes of the second word:
  - next cycle cs=we=oe=0, address=BASE_ADDR, state IDLE
  - restart rewrites from address 0
- DATA_W=16, BASE_ADDR=0x100, RD_LATENCY=3, bytes 11 22 33, last on 33:
  - writes 0x2211@0x100, 0x0033@0x102
  - each RDBACK lasts 3 cycles
